// File: rtl/trellis_max_tree.sv
// Fully pipelined signed arg-max/arg-min search over NUM_STATES trellis path metrics.
// Optional feature macro: TRELLIS_MAX_NORM_EN (metrics normalised to the winning value).
module trellis_max_tree #(
    parameter int WIDTH      = 12,
    parameter int NUM_STATES = 20,
    parameter int IDX_W      = $clog2(NUM_STATES),
    parameter int LAT        = $clog2(NUM_STATES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        symEn,
    input  logic                        minMode,
    input  logic [NUM_STATES*WIDTH-1:0] metrics,
    output logic [IDX_W-1:0]            index,
    output logic [WIDTH-1:0]            bestVal,
    output logic                        symEnDly,
    output logic [NUM_STATES*WIDTH-1:0] normMetrics
);

    // Candidates left after s tree stages; s <= 0 is the capture stage.
    function automatic int stage_cnt(input int s);
        int n = NUM_STATES;
        for (int i = 0; i < s; i++) n = (n + 1) / 2;
        return n;
    endfunction

    for (genvar s = 0; s <= LAT; s++) begin : g_stg
        logic vld_d, vld_q;

        if (s == 0) begin : g_ctl
            always_comb vld_d = symEn;
        end else begin : g_ctl
            always_comb vld_d = g_stg[s-1].vld_q;
        end

        always_ff @(posedge clk) begin
            if (reset) vld_q <= 1'b0;
            else       vld_q <= vld_d;
        end

        // The final stage has no consumer for the search mode.
        if (s < LAT) begin : g_mode
            logic min_d, min_q;
            if (s == 0) begin : g_src
                always_comb min_d = symEn ? minMode : min_q;
            end else begin : g_src
                always_comb min_d = g_stg[s-1].g_mode.min_q;
            end
            always_ff @(posedge clk) min_q <= min_d;
        end

        for (genvar j = 0; j < stage_cnt(s); j++) begin : g_el
            logic signed [WIDTH-1:0] val_d, val_q;
            logic [IDX_W-1:0]        idx_d, idx_q;

            if (s == 0) begin : g_src
                always_comb begin
                    val_d = symEn ? $signed(metrics[j*WIDTH +: WIDTH]) : val_q;
                    idx_d = IDX_W'(j);
                end
            end else if (2*j + 1 < stage_cnt(s - 1)) begin : g_src
                logic signed [WIDTH-1:0] lv, rv;
                logic                    take_right;
                assign lv = g_stg[s-1].g_el[2*j].val_q;
                assign rv = g_stg[s-1].g_el[2*j+1].val_q;
                // Strict compares: a tie keeps the left (lower-index) candidate.
                always_comb begin
                    take_right = g_stg[s-1].g_mode.min_q ? (rv < lv) : (rv > lv);
                    val_d      = take_right ? rv : lv;
                    idx_d      = take_right ? g_stg[s-1].g_el[2*j+1].idx_q
                                            : g_stg[s-1].g_el[2*j].idx_q;
                end
            end else begin : g_src
                always_comb begin
                    val_d = g_stg[s-1].g_el[2*j].val_q;
                    idx_d = g_stg[s-1].g_el[2*j].idx_q;
                end
            end

            // NOTE: datapath flops carry no reset; the valid bits alone qualify them.
            always_ff @(posedge clk) begin
                val_q <= val_d;
                idx_q <= idx_d;
            end
        end
    end

    logic                    fin_vld;
    logic [IDX_W-1:0]        fin_idx;
    logic signed [WIDTH-1:0] fin_val;
    assign fin_vld = g_stg[LAT].vld_q;
    assign fin_idx = g_stg[LAT].g_el[0].idx_q;
    assign fin_val = g_stg[LAT].g_el[0].val_q;

    logic [IDX_W-1:0] index_d, index_q;
    logic [WIDTH-1:0] best_val_d, best_val_q;
    logic             sym_en_dly_d, sym_en_dly_q;

    always_comb begin
        sym_en_dly_d = fin_vld;
        index_d      = fin_vld ? fin_idx : index_q;
        best_val_d   = fin_vld ? fin_val : best_val_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q      <= '0;
            best_val_q   <= '0;
            sym_en_dly_q <= 1'b0;
        end else begin
            index_q      <= index_d;
            best_val_q   <= best_val_d;
            sym_en_dly_q <= sym_en_dly_d;
        end
    end

    assign index    = index_q;
    assign bestVal  = best_val_q;
    assign symEnDly = sym_en_dly_q;

`ifdef TRELLIS_MAX_NORM_EN
    logic [NUM_STATES*WIDTH-1:0] cap_flat;
    logic [NUM_STATES*WIDTH-1:0] dly_d [1:LAT];
    logic [NUM_STATES*WIDTH-1:0] dly_q [1:LAT];
    logic [NUM_STATES*WIDTH-1:0] norm_d, norm_q;

    for (genvar k = 0; k < NUM_STATES; k++) begin : g_flat
        assign cap_flat[k*WIDTH +: WIDTH] = g_stg[0].g_el[k].val_q;
    end

    // a - b evaluated one bit wider, then clamped back into the signed WIDTH range.
    function automatic logic [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        logic [WIDTH:0] diff;
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (diff[WIDTH] != diff[WIDTH-1])
            return diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return diff[WIDTH-1:0];
    endfunction

    always_comb begin
        dly_d[1] = cap_flat;
        for (int i = 2; i <= LAT; i++) dly_d[i] = dly_q[i-1];
        norm_d = norm_q;
        if (fin_vld)
            for (int k = 0; k < NUM_STATES; k++)
                norm_d[k*WIDTH +: WIDTH] = sat_sub(dly_q[LAT][k*WIDTH +: WIDTH], fin_val);
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i <= LAT; i++) dly_q[i] <= dly_d[i];
        if (reset) norm_q <= '0;
        else       norm_q <= norm_d;
    end

    assign normMetrics = norm_q;
`else
    assign normMetrics = '0;
`endif

endmodule

// File: tb/tb_trellis_max_tree.sv
// Bench for trellis_max_tree: N = 20, 2, 7, 64 instances checked every cycle against
// a linear-scan arg-max/arg-min model, plus hand-computed directed results.
`timescale 1ns/1ps
module tb_trellis_max_tree;
    localparam int W = 12;

    typedef struct {
        int cap;
        int due;
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [3:0]      sym = '0;
    logic [3:0]      mode = '0;
    logic [20*W-1:0] m0 = '0;
    logic [2*W-1:0]  m1 = '0;
    logic [7*W-1:0]  m2 = '0;
    logic [64*W-1:0] m3 = '0;
    logic [4:0]      idx0;
    logic [0:0]      idx1;
    logic [2:0]      idx2;
    logic [5:0]      idx3;
    logic [W-1:0]    val0, val1, val2, val3;
    logic [3:0]      dly;
    logic [20*W-1:0] nm0;
    logic [2*W-1:0]  nm1;
    logic [7*W-1:0]  nm2;
    logic [64*W-1:0] nm3;

    exp_t q [4][$];
    int   ns [4] = '{20, 2, 7, 64};
    int   mv [64];
    int   last_idx [4] = '{0, 0, 0, 0};
    int   last_val [4] = '{0, 0, 0, 0};
    logic rst_prev = 1'b1;
    int   wins [4] = '{2, 17, 9, 0};

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trellis_max_tree #(.WIDTH(W), .NUM_STATES(20)) dut20 (
        .clk(clk), .reset(reset), .symEn(sym[0]), .minMode(mode[0]), .metrics(m0),
        .index(idx0), .bestVal(val0), .symEnDly(dly[0]), .normMetrics(nm0));
    trellis_max_tree #(.WIDTH(W), .NUM_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .symEn(sym[1]), .minMode(mode[1]), .metrics(m1),
        .index(idx1), .bestVal(val1), .symEnDly(dly[1]), .normMetrics(nm1));
    trellis_max_tree #(.WIDTH(W), .NUM_STATES(7)) dut7 (
        .clk(clk), .reset(reset), .symEn(sym[2]), .minMode(mode[2]), .metrics(m2),
        .index(idx2), .bestVal(val2), .symEnDly(dly[2]), .normMetrics(nm2));
    trellis_max_tree #(.WIDTH(W), .NUM_STATES(64)) dut64 (
        .clk(clk), .reset(reset), .symEn(sym[3]), .minMode(mode[3]), .metrics(m3),
        .index(idx3), .bestVal(val3), .symEnDly(dly[3]), .normMetrics(nm3));

`ifdef TRELLIS_MAX_NORM_EN
    logic            sym8 = 1'b0;
    logic            mode8 = 1'b0;
    logic [20*8-1:0] m8 = '0;
    logic [4:0]      idx8;
    logic [7:0]      val8;
    logic            dly8;
    logic [20*8-1:0] nm8;
    trellis_max_tree #(.WIDTH(8), .NUM_STATES(20)) dut_w8 (
        .clk(clk), .reset(reset), .symEn(sym8), .minMode(mode8), .metrics(m8),
        .index(idx8), .bestVal(val8), .symEnDly(dly8), .normMetrics(nm8));
`endif

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rd_idx(input int c);
        case (c)
            0:       return int'(idx0);
            1:       return int'(idx1);
            2:       return int'(idx2);
            default: return int'(idx3);
        endcase
    endfunction

    function automatic int rd_val(input int c);
        case (c)
            0:       return $signed(val0);
            1:       return $signed(val1);
            2:       return $signed(val2);
            default: return $signed(val3);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        sym = '0;
    endtask

    // Drive mv[0..N-1] into instance c and queue the lowest-index extreme as the expected result.
    task automatic send(input int c, input logic mm);
        int   bi, bv;
        logic [31:0] t;
        exp_t e;
        bi = 0;
        bv = mv[0];
        for (int k = 1; k < ns[c]; k++)
            if (mm ? (mv[k] < bv) : (mv[k] > bv)) begin
                bi = k;
                bv = mv[k];
            end
        for (int k = 0; k < ns[c]; k++) begin
            t = mv[k];
            case (c)
                0:       m0[k*W +: W] = t[W-1:0];
                1:       m1[k*W +: W] = t[W-1:0];
                2:       m2[k*W +: W] = t[W-1:0];
                default: m3[k*W +: W] = t[W-1:0];
            endcase
        end
        e.cap = cyc + 1;
        e.due = cyc + $clog2(ns[c]) + 2;
        e.idx = bi;
        e.val = bv;
        q[c].push_back(e);
        sym[c]  = 1'b1;
        mode[c] = mm;
    endtask

    // Every cycle: reset state, a due result with its pulse, or held outputs and no pulse.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (rst_prev) begin
                    while (q[c].size() > 0 && q[c][0].cap <= cyc) void'(q[c].pop_front());
                    last_idx[c] = 0;
                    last_val[c] = 0;
                    check($sformatf("rst_dly%0d", c), dly[c], 0);
                    check($sformatf("rst_idx%0d", c), rd_idx(c), 0);
                    check($sformatf("rst_val%0d", c), rd_val(c), 0);
                end else if (q[c].size() > 0 && q[c][0].due == cyc) begin
                    check($sformatf("pulse%0d", c), dly[c], 1);
                    check($sformatf("idx%0d", c), rd_idx(c), q[c][0].idx);
                    check($sformatf("val%0d", c), rd_val(c), q[c][0].val);
                    last_idx[c] = q[c][0].idx;
                    last_val[c] = q[c][0].val;
                    void'(q[c].pop_front());
                end else begin
                    check($sformatf("idle_dly%0d", c), dly[c], 0);
                    check($sformatf("hold_idx%0d", c), rd_idx(c), last_idx[c]);
                    check($sformatf("hold_val%0d", c), rd_val(c), last_val[c]);
                end
            end
            rst_prev = reset;
        end
    end

    task automatic run_one(input string name, input logic mm, input int e_idx, input int e_val);
        int k0, lat;
        tick();
        send(0, mm);
        k0  = cyc;
        lat = -1;
        tick();
        for (int i = 0; i < 30 && lat < 0; i++) begin
            @(negedge clk);
            if (dly[0]) lat = cyc - k0;
        end
        check({name, "_lat"}, lat, 7);
        check({name, "_idx"}, idx0, e_idx);
        check({name, "_val"}, $signed(val0), e_val);
    endtask

    initial begin
        int got [$];
        int first, lastc, npulse;

        tick();
        tick();
        reset = 1'b0;

        for (int k = 0; k < 20; k++) mv[k] = k;
        run_one("max_ramp", 1'b0, 19, 19);
`ifdef TRELLIS_MAX_NORM_EN
        for (int k = 0; k < 20; k++) mv[k] = 10 * k;
        run_one("norm_ramp", 1'b0, 19, 190);
        check("norm19", $signed(nm0[19*W +: W]), 0);
        check("norm0", $signed(nm0[0 +: W]), -190);
`endif

        for (int k = 0; k < 20; k++) mv[k] = 2047;
        run_one("tie_all", 1'b0, 0, 2047);

        for (int k = 0; k < 20; k++) mv[k] = -50;
        mv[5]  = 100;
        mv[11] = 100;
        run_one("tie_pair", 1'b0, 5, 100);

        for (int k = 0; k < 20; k++) mv[k] = 0;
        mv[3] = -2048;
        run_one("min_neg", 1'b1, 3, -2048);
        run_one("max_neg", 1'b0, 0, 0);

        // Four back-to-back strobes with planted winners.
        for (int b = 0; b < 4; b++) begin
            tick();
            for (int k = 0; k < 20; k++) mv[k] = int'($urandom_range(0, 3000)) - 2048;
            mv[wins[b]] = 2047;
            send(0, 1'b0);
        end
        tick();
        first = -1;
        lastc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dly[0]) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                got.push_back(int'(idx0));
            end
        end
        check("b2b_count", got.size(), 4);
        check("b2b_span", lastc - first, 3);
        for (int b = 0; b < 4; b++)
            check($sformatf("b2b_idx%0d", b), (b < got.size()) ? got[b] : -1, wins[b]);
        check("b2b_hold", idx0, 0);

        // Reset three cycles after a strobe must swallow its result.
        tick();
        for (int k = 0; k < 20; k++) mv[k] = k;
        send(0, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        npulse = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (dly[0]) npulse++;
        end
        check("rst_nopulse", npulse, 0);
        check("rst_idx", idx0, 0);
        check("rst_val", $signed(val0), 0);
        run_one("post_rst", 1'b0, 19, 19);

        // Random traffic on all instances, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            tick();
            reset = (i == 300);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 1) == 1)
                        for (int k = 0; k < ns[c]; k++) mv[k] = int'($urandom_range(0, 6)) - 3;
                    else
                        for (int k = 0; k < ns[c]; k++) mv[k] = int'($urandom_range(0, 4095)) - 2048;
                    send(c, 1'($urandom_range(0, 1)));
                end
            end
        end
        tick();
        reset = 1'b0;
        repeat (12) tick();
        for (int c = 0; c < 4; c++) check($sformatf("drain%0d", c), q[c].size(), 0);

`ifdef TRELLIS_MAX_NORM_EN
        // WIDTH = 8, min mode: -128 wins; 127 - (-128) and 0 - (-128) both clamp to 127.
        tick();
        m8         = '0;
        m8[0 +: 8] = 8'h80;
        m8[8 +: 8] = 8'h7F;
        mode8      = 1'b1;
        sym8       = 1'b1;
        first      = cyc;
        tick();
        sym8  = 1'b0;
        lastc = -1;
        for (int i = 0; i < 30 && lastc < 0; i++) begin
            @(negedge clk);
            if (dly8) lastc = cyc - first;
        end
        check("w8_lat", lastc, 7);
        check("w8_idx", idx8, 0);
        check("w8_val", $signed(val8), -128);
        check("w8_norm1", $signed(nm8[8 +: 8]), 127);
        check("w8_norm0", $signed(nm8[0 +: 8]), 0);
        check("w8_norm2", $signed(nm8[16 +: 8]), 127);
`else
        check("norm_tied", int'(|{nm0, nm1, nm2, nm3}), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
